// File: rtl/pokey_bus_pkg.sv
// Shared types and constants for the POKEY bus master: FSM states, rw encoding, register map.
// Pure declarations; no latency or backpressure of its own.
package pokey_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PHI,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [3:0] AUDF1  = 4'h0;
  localparam logic [3:0] AUDC1  = 4'h1;
  localparam logic [3:0] AUDF2  = 4'h2;
  localparam logic [3:0] AUDC2  = 4'h3;
  localparam logic [3:0] AUDF3  = 4'h4;
  localparam logic [3:0] AUDC3  = 4'h5;
  localparam logic [3:0] AUDF4  = 4'h6;
  localparam logic [3:0] AUDC4  = 4'h7;
  localparam logic [3:0] AUDCTL = 4'h8;
  localparam logic [3:0] STIMER = 4'h9;
  localparam logic [3:0] SKRES  = 4'hA;
  localparam logic [3:0] POTGO  = 4'hB;
  localparam logic [3:0] SEROUT = 4'hD;
  localparam logic [3:0] IRQEN  = 4'hE;
  localparam logic [3:0] SKCTL  = 4'hF;

  typedef struct packed {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] wdata;
  } req_t;

endpackage

// File: rtl/pokey_bus_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, last_grant advances on handshake.
// Zero latency; a requester holding valid waits at most one foreign grant.
module rr_arbiter2
  import pokey_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last_grant)) grant = 2'b01;
    else if (req[1])                       grant = 2'b10;
  end

  // Reset to 1 so port 0 is favoured on the first contested grant.
  always_ff @(posedge clk) begin
    if (rst)          last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
  end

endmodule

// File: rtl/pokey_bus_arbiter.sv
// Shares the POKEY register bus between two ports; sequences setup/strobe/hold after a phi2 pulse.
// Read data returns P+SETUP+STROBE+1 after phi2; ready only in IDLE, so ports stall for a whole access.
module pokey_bus_arbiter
  import pokey_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phi2_en,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_rw,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_rw,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       pokey_en,
  output logic       pokey_rw,
  output logic [3:0] pokey_a,
  output logic [7:0] pokey_d_out,
  output logic       pokey_d_oe,
  input  logic [7:0] pokey_d_in,
  output logic       busy
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state;
  req_t       cur;
  req_t       sel;
  logic       cur_id;
  logic [3:0] cnt;
  logic [1:0] grant;
  logic       idle_ok;
  logic       hs;

  assign idle_ok    = (state == ST_IDLE) && !rst;
  assign req0_ready = idle_ok && grant[0];
  assign req1_ready = idle_ok && grant[1];
  assign hs         = req0_ready || req1_ready;
  assign busy       = (state != ST_IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (hs),
    .grant   (grant)
  );

  always_comb begin
    sel = grant[1] ? {req1_rw, req1_addr, req1_wdata}
                   : {req0_rw, req0_addr, req0_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur         <= '0;
      cur_id      <= 1'b0;
      cnt         <= 4'd0;
      pokey_en    <= 1'b0;
      pokey_rw    <= RW_READ;
      pokey_a     <= 4'd0;
      pokey_d_out <= 8'd0;
      pokey_d_oe  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_rdata   <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            cur      <= sel;
            cur_id   <= grant[1];
            pokey_rw <= sel.rw;
            pokey_a  <= sel.addr;
            state    <= ST_WAIT_PHI;
          end
        end
        ST_WAIT_PHI: begin
          if (phi2_en) begin
            state       <= ST_SETUP;
            cnt         <= SETUP_LD;
            pokey_d_oe  <= (cur.rw == RW_WRITE);
            pokey_d_out <= cur.wdata;
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            state    <= ST_STROBE;
            cnt      <= STROBE_LD;
            pokey_en <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            state    <= ST_HOLD;
            cnt      <= HOLD_LD;
            pokey_en <= 1'b0;
            // Read data is captured on the last strobe cycle and presented in the first hold cycle.
            if (cur.rw == RW_READ) begin
              rsp_valid <= 1'b1;
              rsp_id    <= cur_id;
              rsp_rdata <= pokey_d_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            state       <= ST_IDLE;
            pokey_rw    <= RW_READ;
            pokey_a     <= 4'd0;
            pokey_d_oe  <= 1'b0;
            pokey_d_out <= 8'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
